// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB-Lite master port between the IF and MEM requesters.
// Optional IF anti-starvation guard is built when ARB_STARVE_GUARD_EN is defined.
module ahb_master_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_write,
  input  logic [2:0]        mem_size,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ADDR = 2'b01, S_DATA = 2'b10} state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [2:0] SZ_WORD   = 3'b010;

  state_e            state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic              if_err_q, if_err_d, mem_err_q, mem_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              grant_mem_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  // MEM wins unless IF has been passed over STARVE_LIMIT times in a row
  assign grant_mem_s = mem_req && !(if_req && (starve_q == CNT_W'(STARVE_LIMIT)));

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!if_req) begin
        starve_d = '0;
      end else if (grant_mem_s) begin
        if (starve_q != CNT_W'(STARVE_LIMIT)) begin
          starve_d = starve_q + CNT_W'(1);
        end else begin
          starve_d = starve_q;
        end
      end else begin
        starve_d = '0;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign grant_mem_s = mem_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_err_d    = if_err_q;
    mem_err_d   = mem_err_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req || if_req) begin
          state_d     = S_ADDR;
          htrans_d    = TR_NONSEQ;
          owner_mem_d = grant_mem_s;
          if (grant_mem_s) begin
            haddr_d  = mem_addr;
            hwrite_d = mem_write;
            hsize_d  = mem_size;
            wdata_d  = mem_wdata;
          end else begin
            haddr_d  = if_addr;
            hwrite_d = 1'b0;
            hsize_d  = SZ_WORD;
            wdata_d  = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          state_d  = S_DATA;
          htrans_d = TR_IDLE;
          hwdata_d = wdata_q;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        // Errors and writes return zero data so requesters never see stale bus values
        if (HREADY) begin
          state_d = S_IDLE;
          if (owner_mem_q) begin
            mem_done_d  = 1'b1;
            mem_err_d   = HRESP;
            mem_rdata_d = (HRESP || hwrite_q) ? '0 : HRDATA;
          end else begin
            if_done_d  = 1'b1;
            if_err_d   = HRESP;
            if_rdata_d = HRESP ? '0 : HRDATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d  = S_IDLE;
        htrans_d = TR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= SZ_WORD;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_err_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_err_q    <= if_err_d;
      mem_err_q   <= mem_err_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_err   = mem_err_q;

endmodule
